// File: rtl/fb_downscale.sv
// fb_downscale: produces a half-size copy of a source framebuffer in raster order.
// Each destination pixel is one read burst, then a drain, then one write.
// Build option: define FB_DOWNSCALE_AVG_EN to average each 2x2 source block per
// RGB332 channel. Left undefined, the top-left pixel of each block is copied.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-low reset
//   start      - one-cycle pass request, honoured only when idle
//   src_rdaddr - registered source read address
//   src_q      - source read data, valid RD_LAT cycles after its address
//   dst_wraddr - registered destination write address (dy*DST_W+dx)
//   dst_data   - registered destination write data
//   dst_wren   - destination write strobe, one cycle per pixel
//   busy       - pass in progress
//   done       - one-cycle pulse at pass end
module fb_downscale #(
    parameter int unsigned SRC_W  = 320,
    parameter int unsigned SRC_H  = 240,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [18:0] src_rdaddr,
    input  logic [7:0]  src_q,
    output logic [18:0] dst_wraddr,
    output logic [7:0]  dst_data,
    output logic        dst_wren,
    output logic        busy,
    output logic        done
);
    localparam int unsigned AW    = 19;
    localparam int unsigned DST_W = SRC_W / 2;
    localparam int unsigned DST_H = SRC_H / 2;
    localparam int unsigned NPIX  = DST_W * DST_H;
`ifdef FB_DOWNSCALE_AVG_EN
    localparam int unsigned NRD   = 4;
`else
    localparam int unsigned NRD   = 1;
`endif

    typedef enum logic [2:0] {IDLE, RD, DRAIN, WR, FIN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [AW-1:0]       dx_q, dx_d;
    logic [AW-1:0]       base_q, base_d;
    logic [AW-1:0]       pix_q, pix_d;
    logic [AW-1:0]       src_rdaddr_q, src_rdaddr_d;
    logic                addr_vld_q, addr_vld_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [AW-1:0]       dst_wraddr_q, dst_wraddr_d;
    logic [7:0]          dst_data_q, dst_data_d;
    logic                dst_wren_q, dst_wren_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          sample;
    logic [AW-1:0]       rd_off;
`ifdef FB_DOWNSCALE_AVG_EN
    logic [4:0]          acc_r_q, acc_r_d, sum_r;
    logic [4:0]          acc_g_q, acc_g_d, sum_g;
    logic [3:0]          acc_b_q, acc_b_d, sum_b;
`endif

    // Only tagged return cycles contribute source data.
    assign sample = vld_q[RD_LAT-1] ? src_q : 8'h00;
    // Burst order: top-left, top-right, bottom-left, bottom-right.
    assign rd_off = (cnt_q[1] ? AW'(SRC_W) : AW'(0)) + AW'(cnt_q[0]);

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dx_d         = dx_q;
        base_d       = base_q;
        pix_d        = pix_q;
        src_rdaddr_d = src_rdaddr_q;
        addr_vld_d   = 1'b0;
        vld_d        = (vld_q << 1) | RD_LAT'(addr_vld_q);
        dst_wraddr_d = dst_wraddr_q;
        dst_data_d   = dst_data_q;
        dst_wren_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef FB_DOWNSCALE_AVG_EN
        sum_r   = acc_r_q + 5'(sample[7:5]);
        sum_g   = acc_g_q + 5'(sample[4:2]);
        sum_b   = acc_b_q + 4'(sample[1:0]);
        acc_r_d = sum_r;
        acc_g_d = sum_g;
        acc_b_d = sum_b;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD;
                    cnt_d   = 2'd0;
                    dx_d    = '0;
                    base_d  = '0;
                    pix_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RD: begin
                src_rdaddr_d = base_q + rd_off;
                addr_vld_d   = 1'b1;
                cnt_d        = cnt_q + 2'd1;
                if (cnt_q == 2'(NRD - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(RD_LAT - 1)) begin
                    state_d = WR;
                    cnt_d   = 2'd0;
                end
            end
            WR: begin
                // The last tagged sample of the burst arrives in this cycle.
`ifdef FB_DOWNSCALE_AVG_EN
                dst_data_d = {sum_r[4:2], sum_g[4:2], sum_b[3:2]};
                acc_r_d    = '0;
                acc_g_d    = '0;
                acc_b_d    = '0;
`else
                dst_data_d = sample;
`endif
                dst_wraddr_d = pix_q;
                dst_wren_d   = 1'b1;
                pix_d        = pix_q + AW'(1);
                // Row wrap skips the odd source row of the block just finished.
                if (dx_q == AW'(DST_W - 1)) begin
                    dx_d   = '0;
                    base_d = base_q + AW'(SRC_W + 2);
                end else begin
                    dx_d   = dx_q + AW'(1);
                    base_d = base_q + AW'(2);
                end
                if (pix_q == AW'(NPIX - 1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = RD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dx_q         <= '0;
            base_q       <= '0;
            pix_q        <= '0;
            src_rdaddr_q <= '0;
            addr_vld_q   <= 1'b0;
            vld_q        <= '0;
            dst_wraddr_q <= '0;
            dst_data_q   <= '0;
            dst_wren_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef FB_DOWNSCALE_AVG_EN
            acc_r_q      <= '0;
            acc_g_q      <= '0;
            acc_b_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dx_q         <= dx_d;
            base_q       <= base_d;
            pix_q        <= pix_d;
            src_rdaddr_q <= src_rdaddr_d;
            addr_vld_q   <= addr_vld_d;
            vld_q        <= vld_d;
            dst_wraddr_q <= dst_wraddr_d;
            dst_data_q   <= dst_data_d;
            dst_wren_q   <= dst_wren_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef FB_DOWNSCALE_AVG_EN
            acc_r_q      <= acc_r_d;
            acc_g_q      <= acc_g_d;
            acc_b_q      <= acc_b_d;
`endif
        end
    end

    assign src_rdaddr = src_rdaddr_q;
    assign dst_wraddr = dst_wraddr_q;
    assign dst_data   = dst_data_q;
    assign dst_wren   = dst_wren_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fb_downscale.sv
// tb_fb_downscale: scoreboard bench for fb_downscale on a small 16x8 source.
// Instance a uses RD_LAT=1, instance b uses RD_LAT=3; both must write identical
// images. Works with or without FB_DOWNSCALE_AVG_EN defined.
module tb_fb_downscale;
    localparam int unsigned SW   = 16;
    localparam int unsigned SH   = 8;
    localparam int unsigned DW   = SW / 2;
    localparam int unsigned DH   = SH / 2;
    localparam int unsigned NPIX = DW * DH;
`ifdef FB_DOWNSCALE_AVG_EN
    localparam int unsigned NRD  = 4;
`else
    localparam int unsigned NRD  = 1;
`endif
    localparam int unsigned PER_A  = NRD + 1 + 1;
    localparam int unsigned PER_B  = NRD + 3 + 1;
    localparam int unsigned BUDGET = NPIX * PER_B + 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [18:0] src_rdaddr_a, dst_wraddr_a, src_rdaddr_b, dst_wraddr_b;
    logic [7:0]  src_q_a, dst_data_a, src_q_b, dst_data_b;
    logic        dst_wren_a, busy_a, done_a, dst_wren_b, busy_b, done_b;

    logic [7:0]  mem [SW*SH];
    logic [18:0] ap_a;
    logic [18:0] ap_b [3];
    logic [26:0] q_a [$];
    logic [26:0] q_b [$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int wr_a = 0, wr_b = 0, first_wr_a = 0, first_wr_b = 0, last_wr_a = 0, last_wr_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0, done_cyc_a = 0, done_cyc_b = 0;
    int unsigned off [4] = '{0, 1, SW, SW + 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fb_downscale #(.SRC_W(SW), .SRC_H(SH), .RD_LAT(1)) u_a (
        .clk(clk), .reset(reset), .start(start),
        .src_rdaddr(src_rdaddr_a), .src_q(src_q_a),
        .dst_wraddr(dst_wraddr_a), .dst_data(dst_data_a), .dst_wren(dst_wren_a),
        .busy(busy_a), .done(done_a)
    );

    fb_downscale #(.SRC_W(SW), .SRC_H(SH), .RD_LAT(3)) u_b (
        .clk(clk), .reset(reset), .start(start),
        .src_rdaddr(src_rdaddr_b), .src_q(src_q_b),
        .dst_wraddr(dst_wraddr_b), .dst_data(dst_data_b), .dst_wren(dst_wren_b),
        .busy(busy_b), .done(done_b)
    );

    // Source RAM models with 1 and 3 cycles of read latency.
    always @(posedge clk) begin
        ap_a    <= src_rdaddr_a;
        ap_b[0] <= src_rdaddr_b;
        ap_b[1] <= ap_b[0];
        ap_b[2] <= ap_b[1];
    end
    assign src_q_a = (ap_a < 19'(SW*SH)) ? mem[7'(ap_a)] : 8'h00;
    assign src_q_b = (ap_b[2] < 19'(SW*SH)) ? mem[7'(ap_b[2])] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(int unsigned dx, int unsigned dy);
        int unsigned b;
        b = 2 * dy * SW + 2 * dx;
`ifdef FB_DOWNSCALE_AVG_EN
        begin
            logic [7:0] p [4];
            int unsigned r, g, bl;
            p = '{mem[b], mem[b+1], mem[b+SW], mem[b+SW+1]};
            r = 0; g = 0; bl = 0;
            for (int i = 0; i < 4; i++) begin
                r  += int'(p[i][7:5]);
                g  += int'(p[i][4:2]);
                bl += int'(p[i][1:0]);
            end
            return {3'(r / 4), 3'(g / 4), 2'(bl / 4)};
        end
`else
        return mem[b];
`endif
    endfunction

    // Write monitors: pop expectations, check order, data and pixel period.
    always @(negedge clk) begin
        logic [26:0] e;
        if (dst_wren_a) begin
            chk("a_wr_expected", 32'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a_wr_addr", dst_wraddr_a, e[26:8]);
                chk("a_wr_data", dst_data_a, e[7:0]);
            end
            if (wr_a == 0) first_wr_a = cyc;
            else chk("a_period", cyc - last_wr_a, PER_A);
            last_wr_a = cyc;
            wr_a++;
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
            chk("a_busy_low_at_done", busy_a, 0);
        end
    end

    always @(negedge clk) begin
        logic [26:0] e;
        if (dst_wren_b) begin
            chk("b_wr_expected", 32'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_wr_addr", dst_wraddr_b, e[26:8]);
                chk("b_wr_data", dst_data_b, e[7:0]);
            end
            if (wr_b == 0) first_wr_b = cyc;
            else chk("b_period", cyc - last_wr_b, PER_B);
            last_wr_b = cyc;
            wr_b++;
        end
        if (done_b) begin
            done_cnt_b++;
            done_cyc_b = cyc;
            chk("b_busy_low_at_done", busy_b, 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Returns the cycle number of the edge that sampled start.
    task automatic pulse_start(output int t);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        t = cyc;
    endtask

    task automatic push_all();
        q_a.delete();
        q_b.delete();
        for (int dy = 0; dy < DH; dy++) begin
            for (int dx = 0; dx < DW; dx++) begin
                logic [26:0] e;
                e = {19'(dy * DW + dx), model(dx, dy)};
                q_a.push_back(e);
                q_b.push_back(e);
            end
        end
        wr_a = 0;
        wr_b = 0;
    endtask

    task automatic run_pass(input bit extra_starts);
        int t, n, d0a, d0b;
        push_all();
        d0a = done_cnt_a;
        d0b = done_cnt_b;
        pulse_start(t);
        chk("busy_rise", busy_a, 1);
        for (int k = 0; k < int'(NRD); k++) begin
            step();
            chk("rdaddr_seq", src_rdaddr_a, off[k]);
        end
        step();
        chk("rdaddr_hold", src_rdaddr_a, off[NRD-1]);
        if (extra_starts) begin
            repeat (3) begin
                start = 1'b1;
                step();
                start = 1'b0;
                step();
            end
        end
        n = 0;
        while ((done_cnt_a == d0a || done_cnt_b == d0b) && n < int'(BUDGET)) begin
            step();
            n++;
        end
        chk("pass_within_budget", 32'(n < int'(BUDGET)), 1);
        chk("a_first_wr_latency", first_wr_a - t, PER_A);
        chk("b_first_wr_latency", first_wr_b - t, PER_B);
        chk("a_done_cycle", done_cyc_a - t, NPIX * PER_A);
        chk("b_done_cycle", done_cyc_b - t, NPIX * PER_B);
        repeat (3) step();
        chk("a_done_once", done_cnt_a - d0a, 1);
        chk("b_done_once", done_cnt_b - d0b, 1);
        chk("a_all_written", q_a.size(), 0);
        chk("b_all_written", q_b.size(), 0);
        chk("a_idle_after", busy_a, 0);
        chk("b_idle_after", busy_b, 0);
    endtask

    initial begin
        int t, n, wa, wb, da, db;

        repeat (3) step();
        chk("rst_rdaddr", src_rdaddr_a, 0);
        chk("rst_wraddr", dst_wraddr_a, 0);
        chk("rst_data", dst_data_a, 0);
        chk("rst_wren", dst_wren_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_b_outputs", {busy_b, done_b, dst_wren_b, src_rdaddr_b}, 0);
        reset = 1'b1;
        step();

        // Ramp image, with stray start pulses during the pass.
        for (int i = 0; i < int'(SW*SH); i++) mem[i] = 8'(i);
        run_pass(1'b1);

        // Single red-ish pixel in the corner block, everything else black.
        for (int i = 0; i < int'(SW*SH); i++) mem[i] = 8'h00;
        mem[0] = 8'hE0;
        run_pass(1'b0);

        // Uniform white.
        for (int i = 0; i < int'(SW*SH); i++) mem[i] = 8'hFF;
        run_pass(1'b0);

        // Random image, aborted by reset after the tenth write.
        for (int i = 0; i < int'(SW*SH); i++) mem[i] = 8'($urandom);
        push_all();
        da = done_cnt_a;
        db = done_cnt_b;
        pulse_start(t);
        n = 0;
        while (wr_a < 10 && n < int'(BUDGET)) begin
            step();
            n++;
        end
        chk("reach_ten_writes", wr_a, 10);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_wren", dst_wren_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_b", {dst_wren_b, busy_b, done_b}, 0);
        q_a.delete();
        q_b.delete();
        wa = wr_a;
        wb = wr_b;
        repeat (40) step();
        chk("a_no_wr_after_abort", wr_a, wa);
        chk("b_no_wr_after_abort", wr_b, wb);
        chk("a_no_done_after_abort", done_cnt_a, da);
        chk("b_no_done_after_abort", done_cnt_b, db);

        // Restart after the abort begins again at destination pixel 0.
        run_pass(1'b0);

        // A start that coincides with reset is ignored.
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        reset = 1'b1;
        start = 1'b0;
        chk("rst_start_busy", busy_a, 0);
        wa = wr_a;
        repeat (10) step();
        chk("rst_start_still_idle", {busy_a, busy_b}, 0);
        chk("rst_start_no_wr", wr_a, wa);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
